key_matrix_scanner: RTL and testbench
=====================================

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, 1000, clock cycles each row is driven (legal range 4..65535).
REQ-002 SHALL have parameter DEB_FRAMES, 4, consecutive identical frame results required for acceptance (legal range 1..15).
REQ-003 SHALL have port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port row, output, 4, keypad row drive, active-low, exactly one bit low at any time.
REQ-006 SHALL have port col, input, 4, keypad column sense, active-low (pulled up), asynchronous to clock.
REQ-007 SHALL have port key_in, output, 1, one-cycle pulse marking a newly accepted key press.
REQ-008 SHALL have port key_val, output, 4, code of the last accepted key = row_index*4 + col_index.
REQ-009 SHALL have port key_down, output, 1, level: accepted key currently held.
REQ-010 SHALL have port multi, output, 1, level: stable result is two or more keys pressed.

Function
REQ-011 SHALL pass each col bit through a 2-flop synchronizer before use.
REQ-012 SHALL drive row index r (0..3) low for SCAN_DIV cycles, then advance to r+1, wrapping 3->0; row pattern for index r = all ones except bit r.
REQ-013 SHALL sample the synchronized columns in the last cycle of each row period into frame bits [r*4+3 : r*4] (bit = 1 when pressed).
REQ-014 SHALL, at end of row 3 (end of frame, period 4*SCAN_DIV), classify the 16-bit frame as NONE (0 bits), SINGLE(k) (one bit, k = bit index), or MULTI (2+ bits).
REQ-015 SHALL count consecutive frames with identical classification (including k); a change restarts the count at 1; count saturates at DEB_FRAMES.
REQ-016 SHALL run state machine RELEASED / PRESSED / JAMMED; transitions are evaluated only on the end-of-frame cycle where the count reaches DEB_FRAMES.
REQ-017 RELEASED + stable SINGLE(k): go PRESSED, key_val<=k, key_down<=1, key_in=1 for exactly the next cycle.
REQ-018 RELEASED + stable MULTI: go JAMMED, multi<=1, no key_in pulse, key_val unchanged.
REQ-019 PRESSED + stable NONE: go RELEASED, key_down<=0; PRESSED + stable SINGLE(j), j!=k, or MULTI: stay PRESSED, no pulse (rollover is ignored until full release).
REQ-020 JAMMED + stable NONE: go RELEASED, multi<=0; any other stable result: stay JAMMED.
REQ-021 SHALL never emit key_in in two consecutive cycles; at most one pulse per release-press cycle.
REQ-022 Latency: key_in asserts exactly 1 cycle after the end-of-frame sample completing the DEB_FRAMES-th matching frame.
REQ-023 key_val SHALL hold its value until the next accepted press, including after release.
REQ-024 Row counter and frame processing SHALL run continuously regardless of state.

Reset
REQ-025 On reset low: row=4'b1110, row index 0, divider 0, key_in=0, key_val=0, key_down=0, multi=0, state RELEASED, frame, debounce count and synchronizers cleared.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame; scanning restarts at row 0 on the first edge after release.

Structure
REQ-027 State encodings, row reset pattern 4'b1110 and classification codes SHALL live in shared package/include kappa3_kbd_pkg.
REQ-028 SHALL contain one sub-module scan_timer (divider + row index + end-of-row/end-of-frame strobes); classification, debounce and FSM stay in the top.
REQ-029 Output key_in/key_val SHALL be directly compatible with the existing key buffer input (key_in, key_val).

Verification (SCAN_DIV=4, DEB_FRAMES=2; frame = 16 cycles)
REQ-030 Reset release, no keys -> row sequence 1110,1101,1011,0111 each 4 cycles, repeating; all outputs 0.
REQ-031 Hold row1/col2 (key 6) for 3 frames -> single key_in pulse 1 cycle after 2nd frame end; key_val=6, key_down=1.
REQ-032 Release key 6 for 2 frames -> key_down=0, no pulse, key_val stays 6; press key 15 -> one pulse, key_val=15.
REQ-033 Key 3 bounces (present alternate frames) for 6 frames -> no key_in, key_down=0.
REQ-034 Keys 0 and 5 held 2 frames -> multi=1, no pulse; release 2 frames -> multi=0; then key 0 alone -> pulse, key_val=0.
REQ-035 Assert reset during frame 2 of key 9 press -> outputs cleared instantly; after release, key 9 held -> pulse after 2 full new frames.

Source files
------------

// File: rtl/kappa3_kbd_pkg.sv
// Shared keypad types: scanner FSM states, frame classification and row drive patterns.
// Imported by the scanner top and its scan timer.
package kappa3_kbd_pkg;

   typedef enum logic [1:0] {
      StReleased = 2'd0,
      StPressed  = 2'd1,
      StJammed   = 2'd2
   } kbd_state_e;

   typedef enum logic [1:0] {
      ClsNone   = 2'd0,
      ClsSingle = 2'd1,
      ClsMulti  = 2'd2
   } cls_kind_e;

   // idx is only meaningful for ClsSingle and is forced to 0 otherwise so that
   // whole-struct compares detect a change of classification exactly.
   typedef struct packed {
      cls_kind_e  kind;
      logic [3:0] idx;
   } cls_t;

   localparam logic [3:0] RowReset = 4'b1110;

   function automatic logic [3:0] row_pattern(input logic [1:0] idx);
      logic [3:0] pat;
      pat      = 4'b1111;
      pat[idx] = 1'b0;
      return pat;
   endfunction

   function automatic cls_t classify(input logic [15:0] frame);
      cls_t        c;
      int unsigned n;
      c.kind = ClsNone;
      c.idx  = 4'd0;
      n      = 0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            n++;
            c.idx = 4'(i);
         end
      end
      if (n == 1) begin
         c.kind = ClsSingle;
      end else if (n > 1) begin
         c.kind = ClsMulti;
         c.idx  = 4'd0;
      end
      return c;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Row scan timebase: holds each row low for SCAN_DIV cycles and flags the last cycle
// of every row period and of every 4-row frame.
module scan_timer
   import kappa3_kbd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic       clock,
   input  logic       reset,
   output logic [3:0] row,
   output logic [1:0] row_idx,
   output logic       end_of_row,
   output logic       end_of_frame
);

   localparam int unsigned     DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      row_idx_q, row_idx_d;
   logic [3:0]      row_q, row_d;

   always_comb begin
      end_of_row   = (div_q == DivLast);
      end_of_frame = end_of_row && (row_idx_q == 2'd3);
      div_d        = end_of_row ? '0 : div_q + 1'b1;
      row_idx_d    = end_of_row ? row_idx_q + 2'd1 : row_idx_q;
      // Row drive is registered so the pins never glitch through a two-low pattern.
      row_d        = row_pattern(row_idx_d);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_q     <= '0;
         row_idx_q <= 2'd0;
         row_q     <= RowReset;
      end else begin
         div_q     <= div_d;
         row_idx_q <= row_idx_d;
         row_q     <= row_d;
      end
   end

   assign row     = row_q;
   assign row_idx = row_idx_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner: synchronizes columns, assembles one 16-bit frame per scan,
// debounces the frame classification and reports accepted presses.
module key_matrix_scanner
   import kappa3_kbd_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned DEB_FRAMES = 4
) (
   input  logic       clock,
   input  logic       reset,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic       key_in,
   output logic [3:0] key_val,
   output logic       key_down,
   output logic       multi
);

   localparam logic [3:0] DebLast = 4'(DEB_FRAMES);

   logic [1:0] row_idx;
   logic       end_of_row;
   logic       end_of_frame;

   scan_timer #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan_timer (
      .clock       (clock),
      .reset       (reset),
      .row         (row),
      .row_idx     (row_idx),
      .end_of_row  (end_of_row),
      .end_of_frame(end_of_frame)
   );

   logic [3:0]  col_s1_q, col_s2_q;
   logic [15:0] frame_q, frame_d, frame_now;
   cls_t        cls_now, last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        stable;
   kbd_state_e  state_q, state_d;
   logic        key_in_q, key_in_d;
   logic [3:0]  key_val_q, key_val_d;
   logic        key_down_q, key_down_d;
   logic        multi_q, multi_d;

   // frame_now already holds the current row, so the end-of-frame classify sees row 3.
   always_comb begin
      frame_now                       = frame_q;
      frame_now[{row_idx, 2'b00} +: 4] = ~col_s2_q;
      frame_d                         = end_of_row ? frame_now : frame_q;
      cls_now                         = classify(frame_now);
      cnt_d                           = cnt_q;
      last_d                          = last_q;
      if (end_of_frame) begin
         last_d = cls_now;
         if (cls_now != last_q) begin
            cnt_d = 4'd1;
         end else if (cnt_q < DebLast) begin
            cnt_d = cnt_q + 4'd1;
         end
      end
      stable = end_of_frame && (cnt_d == DebLast);
   end

   always_comb begin
      state_d    = state_q;
      key_in_d   = 1'b0;
      key_val_d  = key_val_q;
      key_down_d = key_down_q;
      multi_d    = multi_q;
      if (stable) begin
         case (state_q)
            StReleased: begin
               if (cls_now.kind == ClsSingle) begin
                  state_d    = StPressed;
                  key_in_d   = 1'b1;
                  key_val_d  = cls_now.idx;
                  key_down_d = 1'b1;
               end else if (cls_now.kind == ClsMulti) begin
                  state_d = StJammed;
                  multi_d = 1'b1;
               end
            end
            StPressed: begin
               if (cls_now.kind == ClsNone) begin
                  state_d    = StReleased;
                  key_down_d = 1'b0;
               end
            end
            StJammed: begin
               if (cls_now.kind == ClsNone) begin
                  state_d = StReleased;
                  multi_d = 1'b0;
               end
            end
            default: state_d = StReleased;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // Pulled-up idle level: no key seen until real samples arrive.
         col_s1_q   <= 4'hF;
         col_s2_q   <= 4'hF;
         frame_q    <= '0;
         last_q     <= '{kind: ClsNone, idx: 4'd0};
         cnt_q      <= 4'd0;
         state_q    <= StReleased;
         key_in_q   <= 1'b0;
         key_val_q  <= 4'd0;
         key_down_q <= 1'b0;
         multi_q    <= 1'b0;
      end else begin
         col_s1_q   <= col;
         col_s2_q   <= col_s1_q;
         frame_q    <= frame_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         key_in_q   <= key_in_d;
         key_val_q  <= key_val_d;
         key_down_q <= key_down_d;
         multi_q    <= multi_d;
      end
   end

   assign key_in   = key_in_q;
   assign key_val  = key_val_q;
   assign key_down = key_down_q;
   assign multi    = multi_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner with SCAN_DIV=4, DEB_FRAMES=2:
// a keypad model drives col from row, and a frame-level model predicts the outputs.
module tb_key_matrix_scanner;

   localparam int unsigned ScanDiv   = 4;
   localparam int unsigned DebFrames = 2;
   localparam int          FrameLen  = 4 * ScanDiv;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_in;
   logic [3:0]  key_val;
   logic        key_down;
   logic        multi;
   logic [15:0] key_mask = 16'h0000;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Frame-level reference: classification -1 none, 0..15 single key, 16 multi.
   int         m_last;
   int         m_cnt;
   int         m_state;
   logic [3:0] m_kval;
   logic       m_kdown;
   logic       m_multi;
   logic       m_pulse;

   key_matrix_scanner #(
      .SCAN_DIV  (ScanDiv),
      .DEB_FRAMES(DebFrames)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .row     (row),
      .col     (col),
      .key_in  (key_in),
      .key_val (key_val),
      .key_down(key_down),
      .multi   (multi)
   );

   always #5 clock = ~clock;

   // Keypad: a pressed key shorts its column to its row while that row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row[r]) col = col & ~key_mask[r*4 +: 4];
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      m_last  = -1;
      m_cnt   = 0;
      m_state = 0;
      m_kval  = 4'd0;
      m_kdown = 1'b0;
      m_multi = 1'b0;
      m_pulse = 1'b0;
   endtask

   task automatic model_frame(input logic [15:0] mask);
      int cls;
      int n;
      n   = $countones(mask);
      cls = -1;
      if (n > 1) cls = 16;
      else if (n == 1) for (int i = 0; i < 16; i++) if (mask[i]) cls = i;
      if (cls == m_last) m_cnt = (m_cnt + 1 > DebFrames) ? DebFrames : m_cnt + 1;
      else m_cnt = 1;
      m_last  = cls;
      m_pulse = 1'b0;
      if (m_cnt == DebFrames) begin
         if (m_state == 0 && cls >= 0 && cls < 16) begin
            m_state = 1; m_kval = 4'(cls); m_kdown = 1'b1; m_pulse = 1'b1;
         end else if (m_state == 0 && cls == 16) begin
            m_state = 2; m_multi = 1'b1;
         end else if (m_state == 1 && cls == -1) begin
            m_state = 0; m_kdown = 1'b0;
         end else if (m_state == 2 && cls == -1) begin
            m_state = 0; m_multi = 1'b0;
         end
      end
   endtask

   // Holds mask for one whole frame, then checks outputs in the cycle after frame end.
   task automatic run_frame(input logic [15:0] mask, input string tag);
      int         spurious;
      int         row_bad;
      logic [3:0] er;
      key_mask = mask;
      spurious = 0;
      row_bad  = 0;
      for (int i = 0; i < FrameLen; i++) begin
         tick();
         er = 4'b1111;
         er[(cyc / ScanDiv) % 4] = 1'b0;
         if (row !== er) row_bad++;
         if (i < FrameLen - 1 && key_in !== 1'b0) spurious++;
      end
      model_frame(mask);
      checks += 6;
      if (row_bad != 0) begin
         failures++;
         $display("FAIL %s row_seq: bad_cycles=%0d required 0", tag, row_bad);
      end
      if (spurious != 0) begin
         failures++;
         $display("FAIL %s stray_key_in: pulses=%0d required 0", tag, spurious);
      end
      if (key_in !== m_pulse) begin
         failures++;
         $display("FAIL %s key_in: got %b required %b", tag, key_in, m_pulse);
      end
      if (key_val !== m_kval) begin
         failures++;
         $display("FAIL %s key_val: got %0d required %0d", tag, key_val, m_kval);
      end
      if (key_down !== m_kdown) begin
         failures++;
         $display("FAIL %s key_down: got %b required %b", tag, key_down, m_kdown);
      end
      if (multi !== m_multi) begin
         failures++;
         $display("FAIL %s multi: got %b required %b", tag, multi, m_multi);
      end
   endtask

   task automatic release_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc   = 0;
      model_reset();
   endtask

   task automatic test_reset();
      key_mask = 16'h0000;
      reset    = 1'b0;
      #12;
      checks += 2;
      if (row !== 4'b1110) begin
         failures++;
         $display("FAIL reset_row: got %b required 1110", row);
      end
      if ({key_in, key_val, key_down, multi} !== 7'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 0000000",
                  {key_in, key_val, key_down, multi});
      end
      release_reset();
   endtask

   task automatic test_rows();
      logic [3:0] er;
      checks++;
      if (row !== 4'b1110) begin
         failures++;
         $display("FAIL row_first_cycle: got %b required 1110", row);
      end
      for (int i = 0; i < 2 * FrameLen; i++) begin
         tick();
         er = 4'b1111;
         er[(cyc / ScanDiv) % 4] = 1'b0;
         checks++;
         if (row !== er || key_in !== 1'b0 || key_down !== 1'b0 || multi !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle%0d: row=%b key_in=%b key_down=%b multi=%b required row=%b 0 0 0",
                     cyc, row, key_in, key_down, multi, er);
         end
      end
   endtask

   task automatic test_single_press();
      for (int f = 0; f < 3; f++) run_frame(16'h0040, "key6_hold");
      checks++;
      if (key_val !== 4'd6 || key_down !== 1'b1) begin
         failures++;
         $display("FAIL key6_final: key_val=%0d key_down=%b required 6 1", key_val, key_down);
      end
   endtask

   task automatic test_release_repress();
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "key6_release");
      checks++;
      if (key_val !== 4'd6 || key_down !== 1'b0) begin
         failures++;
         $display("FAIL key6_released: key_val=%0d key_down=%b required 6 0", key_val, key_down);
      end
      for (int f = 0; f < 3; f++) run_frame(16'h8000, "key15_hold");
      run_frame(16'h0010, "rollover_key4");
      run_frame(16'h0010, "rollover_key4");
      checks++;
      if (key_val !== 4'd15) begin
         failures++;
         $display("FAIL rollover_ignored: key_val=%0d required 15", key_val);
      end
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "key15_release");
   endtask

   task automatic test_bounce();
      for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 16'h0008 : 16'h0000, "key3_bounce");
      checks++;
      if (key_down !== 1'b0) begin
         failures++;
         $display("FAIL bounce_key_down: got %b required 0", key_down);
      end
   endtask

   task automatic test_multi();
      for (int f = 0; f < 2; f++) run_frame(16'h0021, "keys0_5");
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "multi_release");
      for (int f = 0; f < 2; f++) run_frame(16'h0001, "key0_alone");
      checks++;
      if (key_val !== 4'd0 || key_down !== 1'b1 || multi !== 1'b0) begin
         failures++;
         $display("FAIL key0_final: key_val=%0d key_down=%b multi=%b required 0 1 0",
                  key_val, key_down, multi);
      end
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "key0_release");
   endtask

   task automatic test_reset_mid();
      int k;
      for (int f = 0; f < 2; f++) run_frame(16'h1000, "key12_hold");
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "key12_release");
      run_frame(16'h0200, "key9_frame1");
      k = $urandom_range(1, FrameLen - 2);
      for (int i = 0; i < k; i++) tick();
      #2;
      reset = 1'b0;
      #1;
      checks += 2;
      if ({key_in, key_val, key_down, multi} !== 7'd0) begin
         failures++;
         $display("FAIL midreset_outputs: got %b required 0000000",
                  {key_in, key_val, key_down, multi});
      end
      if (row !== 4'b1110) begin
         failures++;
         $display("FAIL midreset_row: got %b required 1110", row);
      end
      @(posedge clock);
      release_reset();
      for (int f = 0; f < 3; f++) run_frame(16'h0200, "key9_after_reset");
      for (int f = 0; f < 2; f++) run_frame(16'h0000, "key9_release");
   endtask

   task automatic test_random();
      logic [15:0] mask;
      int          k1;
      int          k2;
      mask = 16'h0000;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 1) == 0) begin
            k1 = $urandom_range(0, 15);
            k2 = (k1 + 1 + $urandom_range(0, 14)) % 16;
            case ($urandom_range(0, 3))
               0:       mask = 16'h0000;
               3:       begin mask = 16'h0000; mask[k1] = 1'b1; mask[k2] = 1'b1; end
               default: begin mask = 16'h0000; mask[k1] = 1'b1; end
            endcase
         end
         run_frame(mask, "random");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rows();
      test_single_press();
      test_release_repress();
      test_bounce();
      test_multi();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
